// File: rtl/ram_arbiter2022_pkg.sv
// Shared widths, FSM state encoding and port indices for the two-port RAM arbiter.
package ram_arb_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      LOCKED  = 2'd3
   } arb_state_t;

   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/ram_arbiter2022_if.sv
// Requester and RAM-side signal bundle for ram_arbiter2022; slave = arbiter, master = requesters + RAM.
interface ram_arb_if;
   import ram_arb_pkg::*;

   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              lock0, lock1;
   logic              ack0, ack1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              wrEn;
   logic [ADDR_W-1:0] addr_toRAM;
   logic [DATA_W-1:0] data_toRAM;
   logic [DATA_W-1:0] data_fromRAM;
   logic              busy;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, data_fromRAM,
      output ack0, ack1, rdata0, rdata1, wrEn, addr_toRAM, data_toRAM, busy
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, data_fromRAM,
      input  ack0, ack1, rdata0, rdata1, wrEn, addr_toRAM, data_toRAM, busy
   );

endinterface

// File: rtl/ram_arbiter2022_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] mask,
   output logic       valid,
   output logic       idx
);

   logic [1:0] elig;

   always_comb begin
      elig  = req & ~mask;
      valid = |elig;
      idx   = (elig == 2'b11) ? ~last_grant : elig[1];
   end

endmodule

// File: rtl/ram_arbiter2022.sv
// Serialises CPU (port 0) and host (port 1) accesses onto a single-port synchronous-read RAM.
// Optional bus lock for host read-modify-write is built when ARB_LOCK_EN is defined.
//
// state   | meaning
// IDLE    | arbitrate between eligible requesters
// ISSUE   | RAM samples address / write strobe
// CAPTURE | read data returns; ack and rdata registered
// LOCKED  | only the previous owner may be granted
module ram_arbiter2022
   import ram_arb_pkg::*;
(
   input logic      clk,
   input logic      rst,
   ram_arb_if.slave bus
);

   arb_state_t state, state_next;

   logic              owner, last_grant, is_write, lock_q;
   logic              lock_sel, owner_lock;
   logic              do_grant, do_capture;
   logic              grant_valid, grant_idx;
   logic [1:0]        req_vec, pick_req, mask;
   logic              ack0_q, ack1_q, wr_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;

   assign req_vec = {bus.req1, bus.req0};
   assign mask    = {ack1_q, ack0_q};

`ifdef ARB_LOCK_EN
   assign lock_sel   = grant_idx ? bus.lock1 : bus.lock0;
   assign owner_lock = owner ? bus.lock1 : bus.lock0;
`else
   logic lock_unused;
   assign lock_sel    = 1'b0;
   assign owner_lock  = 1'b0;
   assign lock_unused = bus.lock0 | bus.lock1;
`endif

   always_comb begin
      pick_req = req_vec;
      if (state == LOCKED)
         pick_req = owner ? (req_vec & 2'b10) : (req_vec & 2'b01);
   end

   rr_pick2 u_pick (
      .req        (pick_req),
      .last_grant (last_grant),
      .mask       (mask),
      .valid      (grant_valid),
      .idx        (grant_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      do_capture = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               do_grant   = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = CAPTURE;
         CAPTURE: begin
            do_capture = 1'b1;
            state_next = lock_q ? LOCKED : IDLE;
         end
         LOCKED: begin
            // the owner's ack cycle is masked, so a lock release can be seen right away
            if (grant_valid) begin
               do_grant   = 1'b1;
               state_next = ISSUE;
            end else if (!owner_lock) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= PORT_CPU;
         last_grant <= PORT_HOST;
         is_write   <= 1'b0;
         lock_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         if (state == ISSUE)
            wr_en_q <= 1'b0;
         if (do_grant) begin
            owner    <= grant_idx;
            addr_q   <= grant_idx ? bus.addr1 : bus.addr0;
            wdata_q  <= grant_idx ? bus.wdata1 : bus.wdata0;
            wr_en_q  <= grant_idx ? bus.we1 : bus.we0;
            is_write <= grant_idx ? bus.we1 : bus.we0;
            lock_q   <= lock_sel;
         end
         if (do_capture) begin
            last_grant <= owner;
            if (owner == PORT_HOST) begin
               ack1_q <= 1'b1;
               if (!is_write) rdata1_q <= bus.data_fromRAM;
            end else begin
               ack0_q <= 1'b1;
               if (!is_write) rdata0_q <= bus.data_fromRAM;
            end
         end
      end
   end

   assign bus.ack0       = ack0_q;
   assign bus.ack1       = ack1_q;
   assign bus.rdata0     = rdata0_q;
   assign bus.rdata1     = rdata1_q;
   assign bus.wrEn       = wr_en_q;
   assign bus.addr_toRAM = addr_q;
   assign bus.data_toRAM = wdata_q;
   assign bus.busy       = (state == ISSUE) || (state == CAPTURE);

endmodule

// File: tb/tb_ram_arbiter2022.sv
// Directed bench for ram_arbiter2022 with a behavioural synchronous-read RAM.
module tb_ram_arbiter2022;

   logic clk;
   logic rst;

   ram_arb_if bus ();

   ram_arbiter2022 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [0:8191];
   logic        pre_en;
   logic [12:0] pre_addr;
   logic [15:0] pre_data;

   always @(posedge clk) begin
      if (pre_en)        mem[pre_addr] <= pre_data;
      else if (bus.wrEn) mem[bus.addr_toRAM] <= bus.data_toRAM;
      bus.data_fromRAM <= mem[bus.addr_toRAM];
   end

   typedef struct {
      logic        port;
      logic        we;
      logic [12:0] addr;
      logic [15:0] wdata;
      logic        pre;
      logic [15:0] ram;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];
   int   n_vec = 0;
   int   n_err = 0;

`ifdef ARB_LOCK_EN
   localparam int C_ACK0  = 11;
   localparam int C_ACK1B = 7;
   localparam int C_ISS0  = 9;
`else
   localparam int C_ACK0  = 6;
   localparam int C_ACK1B = 9;
   localparam int C_ISS0  = 4;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic preload(input logic [12:0] a, input logic [15:0] d);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   task automatic drive(input logic p, input logic rq, input logic w,
                        input logic [12:0] a, input logic [15:0] d);
      if (p) begin
         bus.req1 = rq; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = rq; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
      end
   endtask

   function automatic logic ack_of(input logic p);
      return p ? bus.ack1 : bus.ack0;
   endfunction

   function automatic logic [15:0] rdata_of(input logic p);
      return p ? bus.rdata1 : bus.rdata0;
   endfunction

   initial begin
      vecs[0] = '{1'b0, 1'b0, 13'h0010, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 16'h1234, 1'b0, 16'h0000, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 13'h1FFF, 16'h0000, 1'b0, 16'h0000, 16'h1234};
      vecs[3] = '{1'b0, 1'b1, 13'h0010, 16'h5A5A, 1'b0, 16'h0000, 16'hBEEF};
      vecs[4] = '{1'b0, 1'b0, 13'h0010, 16'h0000, 1'b0, 16'h0000, 16'h5A5A};
      vecs[5] = '{1'b1, 1'b0, 13'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
      vecs[6] = '{1'b0, 1'b0, 13'h1ABC, 16'h0000, 1'b1, 16'h0001, 16'h0001};
      vecs[7] = '{1'b1, 1'b1, 13'h0123, 16'h0F0F, 1'b0, 16'h0000, 16'hFFFF};

      rst = 1'b1;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
      bus.lock0 = 1'b0;
      bus.lock1 = 1'b0;

      #2;
      chk("rst_ack0", bus.ack0, 0);
      chk("rst_ack1", bus.ack1, 0);
      chk("rst_wren", bus.wrEn, 0);
      chk("rst_addr", bus.addr_toRAM, 0);
      chk("rst_wdata", bus.data_toRAM, 0);
      chk("rst_rdata0", bus.rdata0, 0);
      chk("rst_rdata1", bus.rdata1, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // single accesses, one at a time
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].pre) preload(vecs[i].addr, vecs[i].ram);
         drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
         chk("issue_addr", bus.addr_toRAM, vecs[i].addr);
         chk("issue_wren", bus.wrEn, vecs[i].we);
         if (vecs[i].we) chk("issue_wdata", bus.data_toRAM, vecs[i].wdata);
         chk("issue_busy", bus.busy, 1);
         @(negedge clk);
         chk("capture_wren", bus.wrEn, 0);
         chk("capture_ack", ack_of(vecs[i].port), 0);
         @(negedge clk);
         chk("ack", ack_of(vecs[i].port), 1);
         chk("rdata", rdata_of(vecs[i].port), vecs[i].exp_rdata);
         chk("ack_busy", bus.busy, 0);
         drive(vecs[i].port, 1'b0, 1'b0, vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
         chk("ack_pulse", ack_of(vecs[i].port), 0);
      end

      // both ports held continuously: strict alternation, one ack per 3 cycles
      preload(13'h0020, 16'h1111);
      preload(13'h0030, 16'h2222);
      drive(1'b0, 1'b1, 1'b0, 13'h0020, 16'h0);
      drive(1'b1, 1'b1, 1'b0, 13'h0030, 16'h0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk("cont_ack0", bus.ack0, (c % 6) == 3);
         chk("cont_ack1", bus.ack1, (c % 6) == 0);
         if ((c % 3) == 1) chk("cont_addr", bus.addr_toRAM, ((c % 6) == 1) ? 32'h20 : 32'h30);
         if ((c % 6) == 3) chk("cont_rdata0", bus.rdata0, 16'h1111);
         if ((c % 6) == 0) chk("cont_rdata1", bus.rdata1, 16'h2222);
      end
      drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0);

      // reset in the middle of a write's ISSUE cycle
      @(negedge clk);
      preload(13'h0055, 16'h7777);
      drive(1'b0, 1'b1, 1'b1, 13'h0055, 16'hAAAA);
      @(negedge clk);
      chk("mid_wren_pre", bus.wrEn, 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_wren", bus.wrEn, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_addr", bus.addr_toRAM, 0);
      chk("mid_wdata", bus.data_toRAM, 0);
      chk("mid_rdata0", bus.rdata0, 0);
      chk("mid_rdata1", bus.rdata1, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_no_ack0", bus.ack0, 0);
      end
      chk("mid_write_aborted", mem[13'h0055], 16'h7777);

      // host read then write with lock, CPU waiting
      preload(13'h0100, 16'h1357);
      preload(13'h0200, 16'h2468);
      drive(1'b1, 1'b1, 1'b0, 13'h0100, 16'h0);
      bus.lock1 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk("lock_ack0", bus.ack0, c == C_ACK0);
         chk("lock_ack1", bus.ack1, (c == 3) || (c == C_ACK1B));
         if (c == 1) drive(1'b0, 1'b1, 1'b0, 13'h0200, 16'h0);
         if (c == 3) begin
            chk("lock_rdata1", bus.rdata1, 16'h1357);
            drive(1'b1, 1'b1, 1'b1, 13'h0100, 16'hCAFE);
         end
         if (c == C_ISS0) chk("lock_cpu_addr", bus.addr_toRAM, 13'h0200);
         if (c == C_ACK0) begin
            chk("lock_rdata0", bus.rdata0, 16'h2468);
            drive(1'b0, 1'b0, 1'b0, 13'h0, 16'h0);
         end
         if (c == C_ACK1B) begin
            drive(1'b1, 1'b0, 1'b0, 13'h0, 16'h0);
            bus.lock1 = 1'b0;
         end
      end
      chk("lock_write_mem", mem[13'h0100], 16'hCAFE);
      chk("lock_rdata1_kept", bus.rdata1, 16'h1357);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
